// File: rtl/ram_rd_pkg.sv
// ram_rd_pkg: shared definitions for the block RAM burst reader.
//   - ADDR_W_DEF / DATA_W_DEF : default RAM address and data widths.
//   - RD_LAT      : RAM read latency in cycles (1, or 2 with the output register).
//   - FIFO_DEPTH  : skid FIFO depth, RD_LAT+1, enough to absorb every read in flight.
//   - FIFO_CNT_W  : width of a 0..FIFO_DEPTH occupancy count.
//   - state_t     : reader FSM encoding IDLE / READ / DRAIN.
// Build option: define RAM_RD_OUTREG_EN when the RAM output register is enabled.
package ram_rd_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

`ifdef RAM_RD_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    localparam int FIFO_DEPTH = RD_LAT + 1;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_burst_reader_fifo.sv
// rd_skid_fifo: small synchronous FIFO holding RAM read data plus the
// end-of-burst tag while the downstream consumer is stalled.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (pointers/count only)
//   push, push_data : write one entry (ignored when full with no pop)
//   pop             : remove head entry (ignored when empty)
//   head            : current head entry (undefined while empty)
//   count, empty    : occupancy and empty flag
// Build option: depth follows FIFO_DEPTH, which tracks RAM_RD_OUTREG_EN.
module rd_skid_fifo
    import ram_rd_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int W     = DATA_W_DEF + 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: read-side burst engine for a simple dual-port block RAM.
// Accepts (start address, length-1) commands, reads the burst through RAM
// port B and streams the bytes out on a valid/ready interface. Reads are
// credit-limited against the skid FIFO so no returning RAM data is lost.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready           : command handshake (ready only in IDLE)
//   cmd_addr, cmd_len             : burst start address, length minus one
//   enb, addrb, doutb             : RAM port B enable, address, read data
//   m_valid/m_ready, m_data       : output byte stream
//   m_last                        : final byte of the burst
//   busy                          : FSM not IDLE
//   done                          : one-cycle pulse after the last byte handshake
// Build option: RAM_RD_OUTREG_EN selects a 2-cycle RAM read latency.
module ram_burst_reader
    import ram_rd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [RD_LAT-1:0]   inflight_q, inflight_d;
    logic [RD_LAT-1:0]   infl_last_q, infl_last_d;
    logic                done_q, done_d;

    logic                  pop;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [FIFO_CNT_W-1:0] inflight_cnt;
    logic [FIFO_CNT_W:0]   credit_used;
    logic                  fifo_empty;
    logic [DATA_W:0]       fifo_head;

    assign pop = m_valid & m_ready;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + FIFO_CNT_W'(inflight_q[i]);
        end
    end

    // Slots already claimed after this cycle's pop; a new read needs a free one.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_cnt}
                       - {{FIFO_CNT_W{1'b0}}, pop};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        enb       = 1'b0;
        cmd_ready = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = {1'b0, cmd_len} + (ADDR_W + 1)'(1);
                    state_d = READ;
                end
            end
            READ: begin
                if (rem_q != '0 && credit_used < (FIFO_CNT_W + 1)'(FIFO_DEPTH)) begin
                    enb    = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - (ADDR_W + 1)'(1);
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Issued-read flags (and their end-of-burst tags) age one slot per
        // cycle; the oldest slot lines up with valid doutb.
        inflight_d     = '0;
        infl_last_d    = '0;
        inflight_d[0]  = enb;
        infl_last_d[0] = enb && (rem_q == (ADDR_W + 1)'(1));
        for (int i = 1; i < RD_LAT; i++) begin
            inflight_d[i]  = inflight_q[i-1];
            infl_last_d[i] = infl_last_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            inflight_q  <= '0;
            infl_last_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
        end
    end

    rd_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W + 1),
        .CNT_W (FIFO_CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q[RD_LAT-1]),
        .push_data ({infl_last_q[RD_LAT-1], doutb}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign addrb   = addr_q;
    assign m_valid = ~fifo_empty;
    // Gate with m_valid so stale FIFO contents never appear on the stream.
    assign m_data  = m_valid ? fifo_head[DATA_W-1:0] : '0;
    assign m_last  = m_valid & fifo_head[DATA_W];
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader with a behavioural block RAM
// (mem[i] = i ^ 8'hA5) and an expected-beat / expected-address scoreboard.
module tb_ram_burst_reader;

`ifdef RAM_RD_OUTREG_EN
    localparam int TB_LAT = 2;
`else
    localparam int TB_LAT = 1;
`endif
    localparam int TB_DEPTH = TB_LAT + 1;
    localparam int LIMIT    = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_len;
    logic       enb;
    logic [7:0] addrb;
    logic [7:0] doutb;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] sb[$];
    logic [7:0] aq[$];

    always #5 clk = ~clk;

    ram_burst_reader dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .enb       (enb),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural RAM port B
    logic [7:0] mem [256];
    logic [7:0] rd_s1;
    always @(posedge clk) if (enb) rd_s1 <= mem[addrb];
`ifdef RAM_RD_OUTREG_EN
    logic [7:0] rd_s2;
    always @(posedge clk) rd_s2 <= rd_s1;
    assign doutb = rd_s2;
`else
    assign doutb = rd_s1;
`endif

    // Stimulus: queue expected addresses and beats, then hold cmd_valid one cycle.
    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue_cmd(input logic [7:0] a, input logic [7:0] l);
        logic [7:0] ad;
        for (int i = 0; i <= int'(l); i++) begin
            ad = a + 8'(i);
            aq.push_back(ad);
            sb.push_back({(i == int'(l)), ad ^ 8'hA5});
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        n_vec++; if (enb !== 1'b0) begin n_err++; $display("FAIL rst_enb: got %b want 0", enb); end
        n_vec++; if (addrb !== 8'h00) begin n_err++; $display("FAIL rst_addrb: got %h want 00", addrb); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL rst_m_last: got %b want 0", m_last); end
        n_vec++; if (m_data !== 8'h00) begin n_err++; $display("FAIL rst_m_data: got %h want 00", m_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int c, first, lastc;
        logic [8:0] e;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL basic_accept: cmd_ready=%b want 1", cmd_ready); end
        issue_cmd(8'h10, 8'd3);
        c = 1; first = -1; lastc = -1;
        while (!done && c < LIMIT) begin
            m_ready = 1'b1;
            #1;
            if (c == 1) begin
                n_vec++; if (enb !== 1'b1) begin n_err++; $display("FAIL basic_enb_T1: got %b want 1", enb); end
            end
            if (enb) begin
                n_vec++; e = {1'b0, (aq.size() > 0) ? aq.pop_front() : 8'hxx};
                if (addrb !== e[7:0]) begin n_err++; $display("FAIL basic_addrb: got %h want %h", addrb, e[7:0]); end
            end
            if (m_valid && m_ready) begin
                n_vec++; e = (sb.size() > 0) ? sb.pop_front() : 9'h1xx;
                if ({m_last, m_data} !== e) begin n_err++; $display("FAIL basic_beat: got last=%b data=%h want last=%b data=%h", m_last, m_data, e[8], e[7:0]); end
                if (first < 0) first = c;
                if (m_last) lastc = c;
            end
            @(posedge clk);
            #1;
            c++;
        end
        n_vec++; if (!done) begin n_err++; $display("FAIL basic_timeout: done=%b want 1", done); end
        n_vec++; if (first !== 2 + TB_LAT) begin n_err++; $display("FAIL basic_first_latency: got %0d want %0d", first, 2 + TB_LAT); end
        n_vec++; if (lastc - first !== 3) begin n_err++; $display("FAIL basic_throughput: got span %0d want 3", lastc - first); end
        n_vec++; if (c !== lastc + 1) begin n_err++; $display("FAIL basic_done_timing: got cycle %0d want %0d", c, lastc + 1); end
        n_vec++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got ready=%b busy=%b want 1 0", cmd_ready, busy); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL basic_missing: got %0d beats left want 0", sb.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        int c, beats;
        logic [8:0] e;
        issue_cmd(8'hFE, 8'd3);
        c = 1; beats = 0;
        while (!done && c < LIMIT) begin
            m_ready = 1'b1;
            #1;
            if (enb) begin
                n_vec++; e = {1'b0, (aq.size() > 0) ? aq.pop_front() : 8'hxx};
                if (addrb !== e[7:0]) begin n_err++; $display("FAIL wrap_addrb: got %h want %h", addrb, e[7:0]); end
            end
            if (m_valid && m_ready) begin
                n_vec++; e = (sb.size() > 0) ? sb.pop_front() : 9'h1xx;
                if ({m_last, m_data} !== e) begin n_err++; $display("FAIL wrap_beat: got last=%b data=%h want last=%b data=%h", m_last, m_data, e[8], e[7:0]); end
                beats++;
            end
            @(posedge clk);
            #1;
            c++;
        end
        n_vec++; if (!done) begin n_err++; $display("FAIL wrap_timeout: done=%b want 1", done); end
        n_vec++; if (beats !== 4 || aq.size() != 0) begin n_err++; $display("FAIL wrap_count: got beats=%0d addr_left=%0d want 4 0", beats, aq.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int c, beats;
        logic [8:0] e;
        logic prev_stall;
        logic [7:0] prev_data;
        issue_cmd(8'h00, 8'hFF);
        c = 1; beats = 0; prev_stall = 1'b0; prev_data = '0;
        while (!done && c < LIMIT) begin
            m_ready = (c % 2 == 1);
            #1;
            n_vec++; if (int'(dut.fifo_count) > TB_DEPTH) begin n_err++; $display("FAIL stall_fifo_count: got %0d want <= %0d", dut.fifo_count, TB_DEPTH); end
            if (prev_stall) begin
                n_vec++; if (m_valid !== 1'b1 || m_data !== prev_data) begin n_err++; $display("FAIL stall_stable: got valid=%b data=%h want 1 %h", m_valid, m_data, prev_data); end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (enb) begin
                n_vec++; e = {1'b0, (aq.size() > 0) ? aq.pop_front() : 8'hxx};
                if (addrb !== e[7:0]) begin n_err++; $display("FAIL stall_addrb: got %h want %h", addrb, e[7:0]); end
            end
            if (m_valid && m_ready) begin
                n_vec++; e = (sb.size() > 0) ? sb.pop_front() : 9'h1xx;
                if ({m_last, m_data} !== e) begin n_err++; $display("FAIL stall_beat: got last=%b data=%h want last=%b data=%h", m_last, m_data, e[8], e[7:0]); end
                beats++;
            end
            @(posedge clk);
            #1;
            c++;
        end
        n_vec++; if (!done) begin n_err++; $display("FAIL stall_timeout: done=%b want 1", done); end
        n_vec++; if (beats !== 256 || sb.size() != 0) begin n_err++; $display("FAIL stall_count: got beats=%0d left=%0d want 256 0", beats, sb.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int c, beats, lastc;
        logic [8:0] e;
        issue_cmd(8'h33, 8'd0);
        c = 1; beats = 0; lastc = -1;
        while (!done && c < LIMIT) begin
            m_ready = 1'b1;
            #1;
            if (m_valid && m_ready) begin
                n_vec++; e = (sb.size() > 0) ? sb.pop_front() : 9'h0xx;
                if ({m_last, m_data} !== e) begin n_err++; $display("FAIL single_beat: got last=%b data=%h want last=%b data=%h", m_last, m_data, e[8], e[7:0]); end
                beats++;
                lastc = c;
            end
            @(posedge clk);
            #1;
            c++;
        end
        n_vec++; if (beats !== 1 || c !== lastc + 1) begin n_err++; $display("FAIL single_count: got beats=%0d done_cycle=%0d want 1 %0d", beats, c, lastc + 1); end
        // Done cycle: the next command must be accepted immediately.
        n_vec++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got done=%b ready=%b want 1 1", done, cmd_ready); end
        aq.delete();
        issue_cmd(8'h40, 8'd1);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: busy=%b want 1", busy); end
        c = 1; beats = 0;
        while (!done && c < LIMIT) begin
            m_ready = 1'b1;
            #1;
            if (m_valid && m_ready) begin
                n_vec++; e = (sb.size() > 0) ? sb.pop_front() : 9'h0xx;
                if ({m_last, m_data} !== e) begin n_err++; $display("FAIL b2b_beat: got last=%b data=%h want last=%b data=%h", m_last, m_data, e[8], e[7:0]); end
                beats++;
            end
            @(posedge clk);
            #1;
            c++;
        end
        n_vec++; if (beats !== 2 || !done) begin n_err++; $display("FAIL b2b_count: got beats=%0d done=%b want 2 1", beats, done); end
        aq.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        int stale;
        logic [8:0] e;
        issue_cmd(8'h80, 8'd15);
        for (int c = 1; c <= 6; c++) begin
            m_ready = 1'b1;
            #1;
            if (m_valid && m_ready) begin
                n_vec++; e = (sb.size() > 0) ? sb.pop_front() : 9'h1xx;
                if ({m_last, m_data} !== e) begin n_err++; $display("FAIL midrst_beat: got last=%b data=%h want last=%b data=%h", m_last, m_data, e[8], e[7:0]); end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        aq.delete();
        #1;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
        n_vec++; if (enb !== 1'b0) begin n_err++; $display("FAIL midrst_enb: got %b want 0", enb); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst_cmd_ready: got %b want 1", cmd_ready); end
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #2;
            if (m_valid || enb) stale++;
        end
        n_vec++; if (stale !== 0) begin n_err++; $display("FAIL midrst_stale: got %0d active cycles want 0", stale); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
